// File: rtl/rv32_regfile_sb.sv
// RV32 integer register file with two write ports and a per-register pending
// scoreboard for outstanding loads; optional write-to-read forwarding.
module rv32_regfile_sb #(
    parameter int REG_NUM = 32,
    parameter int XLEN    = 32,
    parameter int BYPASS  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_ready,
    output logic            rs2_ready,
    input  logic [4:0]      wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wa_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_we,
    input  logic            pend_set,
    input  logic [4:0]      pend_addr,
    output logic            busy_any,
    output logic [5:0]      pend_cnt
);
    localparam int AW = $clog2(REG_NUM);

    logic [AW-1:0] rs1_idx, rs2_idx, wa_idx, wb_idx, pend_idx;
    logic          wa_ok, wb_ok, ps_ok, fwd_en;

    logic [XLEN-1:0]    regs [REG_NUM];
    logic [REG_NUM-1:0] pend_q;
    logic [REG_NUM-1:0] pend_nxt;

    assign rs1_idx  = rs1_addr[AW-1:0];
    assign rs2_idx  = rs2_addr[AW-1:0];
    assign wa_idx   = wa_addr[AW-1:0];
    assign wb_idx   = wb_addr[AW-1:0];
    assign pend_idx = pend_addr[AW-1:0];

    generate
        if (AW < 5) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^{rs1_addr[4:AW], rs2_addr[4:AW], wa_addr[4:AW],
                                      wb_addr[4:AW], pend_addr[4:AW]};
        end
    endgenerate

    // x0 is hardwired: writes and pending marks aimed at it are dropped here.
    assign wa_ok  = wa_we && (wa_idx != '0);
    assign wb_ok  = wb_we && (wb_idx != '0);
    assign ps_ok  = pend_set && (pend_idx != '0);
    assign fwd_en = (BYPASS != 0) && rst_n;

    always_comb begin
        pend_nxt = pend_q;
        if (wb_ok) pend_nxt[wb_idx] = 1'b0;
        // a new load issue outranks a simultaneous load return
        if (ps_ok) pend_nxt[pend_idx] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    function automatic logic [5:0] popcount(input logic [REG_NUM-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < REG_NUM; i++) c = c + {5'd0, v[i]};
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (wb_ok && wb_idx == AW'(i))      regs[i] <= wb_data;
                else if (wa_ok && wa_idx == AW'(i)) regs[i] <= wa_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            pend_cnt <= '0;
        end else begin
            pend_q   <= pend_nxt;
            pend_cnt <= popcount(pend_nxt);
        end
    end

    assign busy_any = (pend_cnt != 6'd0);

    function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] idx);
        logic [XLEN-1:0] d;
        d = regs[idx];
        if (fwd_en && wa_ok && wa_idx == idx) d = wa_data;
        if (fwd_en && wb_ok && wb_idx == idx) d = wb_data;
        if (idx == '0) d = '0;
        return d;
    endfunction

    // rsN_ready is a plain valid flag for rsN_data: 1 means the value on
    // rsN_data is architecturally final (no load outstanding for it).
    function automatic logic read_ready(input logic [AW-1:0] idx);
        return (idx == '0) || !pend_q[idx] || (fwd_en && wb_ok && wb_idx == idx);
    endfunction

    assign rs1_data  = read_data(rs1_idx);
    assign rs2_data  = read_data(rs2_idx);
    assign rs1_ready = read_ready(rs1_idx);
    assign rs2_ready = read_ready(rs2_idx);

endmodule

// File: tb/tb_rv32_regfile_sb.sv
// Bench for rv32_regfile_sb: a 32-entry forwarding instance (a) and a 16-entry
// non-forwarding instance (b) share stimulus and are checked against a model.
module tb_rv32_regfile_sb;
    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, wa_addr, wb_addr, pend_addr;
    logic [31:0] wa_data, wb_data;
    logic        wa_we, wb_we, pend_set;

    logic [31:0] rs1_data_a, rs2_data_a, rs1_data_b, rs2_data_b;
    logic        rs1_ready_a, rs2_ready_a, rs1_ready_b, rs2_ready_b;
    logic        busy_a, busy_b;
    logic [5:0]  cnt_a, cnt_b;

    int n_chk = 0;
    int n_fail = 0;

    // model: index 0 = instance a (32 regs, forwarding), 1 = instance b (16 regs)
    logic [31:0] m_reg  [2][32];
    bit          m_pend [2][32];
    int          m_num  [2] = '{32, 16};
    bit          m_byp  [2] = '{1'b1, 1'b0};

    rv32_regfile_sb #(.REG_NUM(32), .XLEN(32), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_a), .rs2_data(rs2_data_a),
        .rs1_ready(rs1_ready_a), .rs2_ready(rs2_ready_a),
        .wa_addr(wa_addr), .wa_data(wa_data), .wa_we(wa_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_we(wb_we),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .busy_any(busy_a), .pend_cnt(cnt_a)
    );

    rv32_regfile_sb #(.REG_NUM(16), .XLEN(32), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
        .rs1_ready(rs1_ready_b), .rs2_ready(rs2_ready_b),
        .wa_addr(wa_addr), .wa_data(wa_data), .wa_we(wa_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_we(wb_we),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .busy_any(busy_b), .pend_cnt(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic int midx(int k, logic [4:0] a);
        return int'(a) % m_num[k];
    endfunction

    function automatic logic [31:0] exp_data(int k, logic [4:0] a);
        int i;
        i = midx(k, a);
        if (i == 0) return 32'd0;
        if (m_byp[k] && rst_n) begin
            if (wb_we && midx(k, wb_addr) == i) return wb_data;
            if (wa_we && midx(k, wa_addr) == i) return wa_data;
        end
        return m_reg[k][i];
    endfunction

    function automatic logic exp_ready(int k, logic [4:0] a);
        int i;
        i = midx(k, a);
        if (i == 0 || !m_pend[k][i]) return 1'b1;
        return m_byp[k] && rst_n && wb_we && midx(k, wb_addr) == i;
    endfunction

    function automatic logic [5:0] exp_cnt(int k);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[k][i]);
        return 6'(c);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i]  = 32'd0;
                m_pend[k][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        int ia, ib, ip;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            ia = midx(k, wa_addr);
            ib = midx(k, wb_addr);
            ip = midx(k, pend_addr);
            if (wa_we && ia != 0) m_reg[k][ia] = wa_data;
            if (wb_we && ib != 0) m_reg[k][ib] = wb_data;
            if (wb_we) m_pend[k][ib] = 1'b0;
            if (pend_set && ip != 0) m_pend[k][ip] = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        wa_we = 1'b0; wb_we = 1'b0; pend_set = 1'b0;
        wa_addr = 5'd0; wb_addr = 5'd0; pend_addr = 5'd0;
        wa_data = 32'd0; wb_data = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] o_d1(int k); return k == 0 ? rs1_data_a : rs1_data_b; endfunction
    function automatic logic [31:0] o_d2(int k); return k == 0 ? rs2_data_a : rs2_data_b; endfunction
    function automatic logic o_r1(int k); return k == 0 ? rs1_ready_a : rs1_ready_b; endfunction
    function automatic logic o_r2(int k); return k == 0 ? rs2_ready_a : rs2_ready_b; endfunction
    function automatic logic [5:0] o_cnt(int k); return k == 0 ? cnt_a : cnt_b; endfunction
    function automatic logic o_busy(int k); return k == 0 ? busy_a : busy_b; endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick(); tick();
        for (int a = 1; a < 32; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(31 - a + 1);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (o_d1(k) !== 32'd0) begin n_fail++; $display("FAIL reset_rs1_data k=%0d a=%0d: got %h want 0", k, a, o_d1(k)); end
                n_chk++; if (o_r1(k) !== 1'b1) begin n_fail++; $display("FAIL reset_rs1_ready k=%0d a=%0d: got %b want 1", k, a, o_r1(k)); end
                n_chk++; if (o_d2(k) !== 32'd0) begin n_fail++; $display("FAIL reset_rs2_data k=%0d a=%0d: got %h want 0", k, a, o_d2(k)); end
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_busy(k) !== 1'b0) begin n_fail++; $display("FAIL reset_busy k=%0d: got %b want 0", k, o_busy(k)); end
            n_chk++; if (o_cnt(k) !== 6'd0) begin n_fail++; $display("FAIL reset_cnt k=%0d: got %0d want 0", k, o_cnt(k)); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        wa_we = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        @(negedge clk);
        n_chk++; if (rs1_data_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle_a: got %h want deadbeef", rs1_data_a); end
        n_chk++; if (rs1_data_b !== 32'd0) begin n_fail++; $display("FAIL nobypass_same_cycle_b: got %h want 0", rs1_data_b); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_chk++; if (rs1_data_b !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobypass_next_cycle_b: got %h want deadbeef", rs1_data_b); end
        n_chk++; if (rs1_data_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_a: got %h want deadbeef", rs1_data_a); end
    endtask

    task automatic test_pending();
        pend_set = 1'b1; pend_addr = 5'd7; rs1_addr = 5'd7;
        tick();
        idle_inputs();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_r1(k) !== 1'b0) begin n_fail++; $display("FAIL pend_ready k=%0d: got %b want 0", k, o_r1(k)); end
            n_chk++; if (o_cnt(k) !== 6'd1) begin n_fail++; $display("FAIL pend_cnt k=%0d: got %0d want 1", k, o_cnt(k)); end
            n_chk++; if (o_busy(k) !== 1'b1) begin n_fail++; $display("FAIL pend_busy k=%0d: got %b want 1", k, o_busy(k)); end
        end
        tick();
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        @(negedge clk);
        n_chk++; if (rs1_ready_a !== 1'b1) begin n_fail++; $display("FAIL wb_fwd_ready_a: got %b want 1", rs1_ready_a); end
        n_chk++; if (rs1_data_a !== 32'h1234) begin n_fail++; $display("FAIL wb_fwd_data_a: got %h want 1234", rs1_data_a); end
        n_chk++; if (rs1_ready_b !== 1'b0) begin n_fail++; $display("FAIL wb_nofwd_ready_b: got %b want 0", rs1_ready_b); end
        tick();
        idle_inputs();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_cnt(k) !== 6'd0) begin n_fail++; $display("FAIL wb_clear_cnt k=%0d: got %0d want 0", k, o_cnt(k)); end
            n_chk++; if (o_r1(k) !== 1'b1) begin n_fail++; $display("FAIL wb_clear_ready k=%0d: got %b want 1", k, o_r1(k)); end
            n_chk++; if (o_d1(k) !== 32'h1234) begin n_fail++; $display("FAIL wb_data k=%0d: got %h want 1234", k, o_d1(k)); end
        end
    endtask

    task automatic test_collision();
        wa_we = 1'b1; wa_addr = 5'd3; wa_data = 32'h1;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h2;
        pend_set = 1'b1; pend_addr = 5'd3;
        tick();
        idle_inputs();
        rs1_addr = 5'd3;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_d1(k) !== 32'h2) begin n_fail++; $display("FAIL coll_data k=%0d: got %h want 2", k, o_d1(k)); end
            n_chk++; if (o_r1(k) !== 1'b0) begin n_fail++; $display("FAIL coll_pending k=%0d: got %b want 0", k, o_r1(k)); end
            n_chk++; if (o_cnt(k) !== 6'd1) begin n_fail++; $display("FAIL coll_cnt k=%0d: got %0d want 1", k, o_cnt(k)); end
        end
        tick();
        wa_we = 1'b1; wa_addr = 5'd3; wa_data = 32'h9;
        tick();
        idle_inputs();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_d1(k) !== 32'h9) begin n_fail++; $display("FAIL wa_pend_data k=%0d: got %h want 9", k, o_d1(k)); end
            n_chk++; if (o_r1(k) !== 1'b0) begin n_fail++; $display("FAIL wa_keeps_pend k=%0d: got %b want 0", k, o_r1(k)); end
        end
    endtask

    task automatic test_alias();
        wa_we = 1'b1; wa_addr = 5'd20; wa_data = 32'hAA;
        tick();
        idle_inputs();
        rs1_addr = 5'd4; rs2_addr = 5'd20;
        @(negedge clk);
        n_chk++; if (rs1_data_b !== 32'hAA) begin n_fail++; $display("FAIL alias_x4_b: got %h want aa", rs1_data_b); end
        n_chk++; if (rs2_data_b !== 32'hAA) begin n_fail++; $display("FAIL alias_a20_b: got %h want aa", rs2_data_b); end
        n_chk++; if (rs1_data_a !== 32'd0) begin n_fail++; $display("FAIL noalias_x4_a: got %h want 0", rs1_data_a); end
        n_chk++; if (rs2_data_a !== 32'hAA) begin n_fail++; $display("FAIL x20_a: got %h want aa", rs2_data_a); end
        tick();
        wa_we = 1'b1; wa_addr = 5'd16; wa_data = 32'hFF;
        pend_set = 1'b1; pend_addr = 5'd16;
        tick();
        idle_inputs();
        rs1_addr = 5'd0; rs2_addr = 5'd16;
        @(negedge clk);
        n_chk++; if (rs2_data_b !== 32'd0) begin n_fail++; $display("FAIL x0_alias_data_b: got %h want 0", rs2_data_b); end
        n_chk++; if (rs2_ready_b !== 1'b1) begin n_fail++; $display("FAIL x0_alias_ready_b: got %b want 1", rs2_ready_b); end
        n_chk++; if (cnt_b !== 6'd1) begin n_fail++; $display("FAIL x0_alias_cnt_b: got %0d want 1", cnt_b); end
        n_chk++; if (rs1_data_a !== 32'd0) begin n_fail++; $display("FAIL x0_data_a: got %h want 0", rs1_data_a); end
        n_chk++; if (rs2_data_a !== 32'hFF) begin n_fail++; $display("FAIL x16_data_a: got %h want ff", rs2_data_a); end
        n_chk++; if (rs2_ready_a !== 1'b0) begin n_fail++; $display("FAIL x16_pend_a: got %b want 0", rs2_ready_a); end
        n_chk++; if (cnt_a !== 6'd2) begin n_fail++; $display("FAIL x16_cnt_a: got %0d want 2", cnt_a); end
    endtask

    task automatic test_reset_mid();
        for (int r = 1; r <= 3; r++) begin
            pend_set = 1'b1; pend_addr = 5'(r);
            tick();
        end
        idle_inputs();
        n_chk++; if (cnt_a !== 6'd4) begin n_fail++; $display("FAIL pre_reset_cnt_a: got %0d want 4", cnt_a); end
        #2;
        rst_n = 1'b0;
        wa_we = 1'b1; wa_addr = 5'd9; wa_data = 32'h55;
        rs1_addr = 5'd1; rs2_addr = 5'd9;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_cnt(k) !== 6'd0) begin n_fail++; $display("FAIL async_cnt k=%0d: got %0d want 0", k, o_cnt(k)); end
            n_chk++; if (o_busy(k) !== 1'b0) begin n_fail++; $display("FAIL async_busy k=%0d: got %b want 0", k, o_busy(k)); end
            n_chk++; if (o_r1(k) !== 1'b1) begin n_fail++; $display("FAIL async_ready k=%0d: got %b want 1", k, o_r1(k)); end
            n_chk++; if (o_d1(k) !== 32'd0) begin n_fail++; $display("FAIL async_data k=%0d: got %h want 0", k, o_d1(k)); end
            n_chk++; if (o_d2(k) !== 32'd0) begin n_fail++; $display("FAIL reset_nofwd k=%0d: got %h want 0", k, o_d2(k)); end
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        wa_addr = 5'd10; wa_data = 32'h77;
        tick();
        idle_inputs();
        rs1_addr = 5'd10;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_d1(k) !== 32'h77) begin n_fail++; $display("FAIL first_write k=%0d: got %h want 77", k, o_d1(k)); end
            n_chk++; if (o_d2(k) !== 32'd0) begin n_fail++; $display("FAIL write_in_reset k=%0d: got %h want 0", k, o_d2(k)); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wa_we = ($urandom_range(0, 1) == 1);
            wb_we = ($urandom_range(0, 2) == 0);
            pend_set = ($urandom_range(0, 2) == 0);
            wa_addr = 5'($urandom_range(0, 31));
            wb_addr = ($urandom_range(0, 1) == 1) ? pend_addr : 5'($urandom_range(0, 31));
            pend_addr = 5'($urandom_range(0, 31));
            wa_data = $urandom;
            wb_data = $urandom;
            rs1_addr = ($urandom_range(0, 2) == 0) ? wb_addr : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 2) == 0) ? wa_addr : 5'($urandom_range(0, 31));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (o_d1(k) !== exp_data(k, rs1_addr)) begin n_fail++; $display("FAIL rnd_rs1_data k=%0d c=%0d: got %h want %h", k, c, o_d1(k), exp_data(k, rs1_addr)); end
                n_chk++; if (o_d2(k) !== exp_data(k, rs2_addr)) begin n_fail++; $display("FAIL rnd_rs2_data k=%0d c=%0d: got %h want %h", k, c, o_d2(k), exp_data(k, rs2_addr)); end
                n_chk++; if (o_r1(k) !== exp_ready(k, rs1_addr)) begin n_fail++; $display("FAIL rnd_rs1_ready k=%0d c=%0d: got %b want %b", k, c, o_r1(k), exp_ready(k, rs1_addr)); end
                n_chk++; if (o_r2(k) !== exp_ready(k, rs2_addr)) begin n_fail++; $display("FAIL rnd_rs2_ready k=%0d c=%0d: got %b want %b", k, c, o_r2(k), exp_ready(k, rs2_addr)); end
                n_chk++; if (o_cnt(k) !== exp_cnt(k)) begin n_fail++; $display("FAIL rnd_cnt k=%0d c=%0d: got %0d want %0d", k, c, o_cnt(k), exp_cnt(k)); end
                n_chk++; if (o_busy(k) !== (exp_cnt(k) != 6'd0)) begin n_fail++; $display("FAIL rnd_busy k=%0d c=%0d: got %b want %b", k, c, o_busy(k), exp_cnt(k) != 6'd0); end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_pending();
        test_collision();
        test_alias();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
